// File: rtl/board_pkg.sv
// Shared types and helpers for the gravity-drop board controller.
// Holds the FSM/winner encodings, the scan-direction step table and the
// (row, col) -> bit-index mapping used by both the controller and the scanner.
package board_pkg;

  typedef enum logic [1:0] {
    WIN_NONE   = 2'b00,
    WIN_RED    = 2'b01,
    WIN_YELLOW = 2'b10,
    WIN_DRAW   = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DROP,
    S_CHECK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_t;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } step_t;

  // Entry d is the forward (dr,dc) step of direction d:
  // H=(0,+1), V=(+1,0), D=(+1,+1), A=(+1,-1).
  localparam logic [3:0][3:0] STEP_TABLE = {4'b01_11, 4'b01_01, 4'b01_00, 4'b00_01};

  function automatic step_t step_of(dir_t d);
    return step_t'(STEP_TABLE[d]);
  endfunction

  function automatic int unsigned cell_idx(int unsigned r, int unsigned c, int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/board_win_scan.sv
// Sequential line-of-WIN_LEN detector around the most recent drop.
// Ports: clk, reset (async active-low), start (pulse, first cell is examined
// in the start cycle), board (mover's occupancy), r/c (dropped cell, held
// stable until done), done/win (registered one-cycle result).
module board_win_scan
  import board_pkg::*;
#(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 7,
  parameter int unsigned WIN_LEN = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ROWS*COLS-1:0]         board,
  input  logic [$clog2(ROWS+1)-1:0]    r,
  input  logic [$clog2(COLS)-1:0]      c,
  output logic                         done,
  output logic                         win
);

  localparam int unsigned PW   = $clog2(((ROWS > COLS) ? ROWS : COLS) + 1) + 2;
  localparam int unsigned RUNW = $clog2(WIN_LEN + 1);
  localparam int unsigned IW   = $clog2(ROWS * COLS);
  localparam logic signed [PW-1:0] ROW_LIM = PW'(ROWS);
  localparam logic signed [PW-1:0] COL_LIM = PW'(COLS);

  logic                   active_q, active_d;
  dir_t                   dir_q, dir_d;
  logic                   bwd_q, bwd_d;
  logic [RUNW-1:0]        run_q, run_d;
  logic signed [PW-1:0]   pr_q, pr_d, pc_q, pc_d;
  logic                   done_d, win_d;

  dir_t                   cur_dir, nxt_dir;
  logic                   cur_bwd, in_bounds, hit;
  logic [RUNW-1:0]        cur_run;
  logic signed [PW-1:0]   cur_r, cur_c, org_r, org_c;
  step_t                  st, nst;
  logic [IW-1:0]          idx;

  assign org_r = signed'(PW'(r));
  assign org_c = signed'(PW'(c));

  // Walker state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      dir_q    <= DIR_H;
      bwd_q    <= 1'b0;
      run_q    <= '0;
      pr_q     <= '0;
      pc_q     <= '0;
      done     <= 1'b0;
      win      <= 1'b0;
    end else begin
      active_q <= active_d;
      dir_q    <= dir_d;
      bwd_q    <= bwd_d;
      run_q    <= run_d;
      pr_q     <= pr_d;
      pc_q     <= pc_d;
      done     <= done_d;
      win      <= win_d;
    end
  end

  // One cell per cycle: extend the run on a hit, else flip half-walk or direction
  always_comb begin
    active_d = active_q;
    dir_d    = dir_q;
    bwd_d    = bwd_q;
    run_d    = run_q;
    pr_d     = pr_q;
    pc_d     = pc_q;
    done_d   = 1'b0;
    win_d    = 1'b0;

    cur_dir  = start ? DIR_H : dir_q;
    cur_bwd  = start ? 1'b0 : bwd_q;
    cur_run  = start ? RUNW'(1) : run_q;
    st       = step_of(cur_dir);
    cur_r    = start ? (org_r + PW'(st.dr)) : pr_q;
    cur_c    = start ? (org_c + PW'(st.dc)) : pc_q;
    nxt_dir  = dir_t'(2'(cur_dir) + 2'd1);
    nst      = step_of(nxt_dir);

    in_bounds = !cur_r[PW-1] && (cur_r < ROW_LIM) && !cur_c[PW-1] && (cur_c < COL_LIM);
    idx       = IW'(cell_idx(32'(unsigned'(cur_r)), 32'(unsigned'(cur_c)), COLS));
    hit       = in_bounds && board[idx];

    if (start || active_q) begin
      active_d = 1'b1;
      dir_d    = cur_dir;
      bwd_d    = cur_bwd;
      run_d    = cur_run;
      if (hit && ((cur_run + RUNW'(1)) >= RUNW'(WIN_LEN))) begin
        done_d   = 1'b1;
        win_d    = 1'b1;
        active_d = 1'b0;
      end else if (hit) begin
        run_d = cur_run + RUNW'(1);
        pr_d  = cur_bwd ? (cur_r - PW'(st.dr)) : (cur_r + PW'(st.dr));
        pc_d  = cur_bwd ? (cur_c - PW'(st.dc)) : (cur_c + PW'(st.dc));
      end else if (!cur_bwd) begin
        // Backward half-walk keeps the run collected going forward
        bwd_d = 1'b1;
        pr_d  = org_r - PW'(st.dr);
        pc_d  = org_c - PW'(st.dc);
      end else if (cur_dir == DIR_A) begin
        done_d   = 1'b1;
        active_d = 1'b0;
      end else begin
        dir_d = nxt_dir;
        bwd_d = 1'b0;
        run_d = RUNW'(1);
        pr_d  = org_r + PW'(nst.dr);
        pc_d  = org_c + PW'(nst.dc);
      end
    end
  end

endmodule

// File: rtl/board_game_ctrl.sv
// ROWS x COLS gravity-drop game controller with automatic turn alternation,
// sequential win detection and draw detection.
// Ports: clk, reset (async active-low), col_switch (one-hot column),
// place_en (level, edge-detected), new_game (sync clear, honoured in IDLE),
// red_player/yellow_player (bit r*COLS+c), turn_red, busy, valid_move,
// invalid_move, game_over, winner, move_count. All outputs registered.
module board_game_ctrl
  import board_pkg::*;
#(
  parameter int unsigned ROWS      = 6,
  parameter int unsigned COLS      = 7,
  parameter int unsigned WIN_LEN   = 4,
  parameter logic        FIRST_RED = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COLS-1:0]                 col_switch,
  input  logic                            place_en,
  input  logic                            new_game,
  output logic [ROWS*COLS-1:0]            red_player,
  output logic [ROWS*COLS-1:0]            yellow_player,
  output logic                            turn_red,
  output logic                            busy,
  output logic                            valid_move,
  output logic                            invalid_move,
  output logic                            game_over,
  output logic [1:0]                      winner,
  output logic [$clog2(ROWS*COLS+1)-1:0]  move_count
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned HW    = $clog2(ROWS + 1);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned MW    = $clog2(CELLS + 1);

  state_t            state_q, state_d;
  logic              place_en_q, place_en_d;
  logic [HW-1:0]     height_q [COLS];
  logic [HW-1:0]     height_d [COLS];
  logic [HW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              mover_red_q, mover_red_d;
  logic [CELLS-1:0]  red_d, yellow_d, drop_bit, mover_board;
  logic              turn_red_d, busy_d, valid_d, invalid_d, game_over_d;
  logic [1:0]        winner_d;
  logic [MW-1:0]     move_count_d;
  logic              place_req, one_hot;
  logic [CW-1:0]     sel_col;
  logic              scan_start, scan_done, scan_win;

  assign place_req   = place_en & ~place_en_q;
  assign scan_start  = (state_q == S_DROP);
  assign mover_board = mover_red_q ? red_player : yellow_player;

  board_win_scan #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .WIN_LEN (WIN_LEN)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .start (scan_start),
    .board (mover_board),
    .r     (row_q),
    .c     (col_q),
    .done  (scan_done),
    .win   (scan_win)
  );

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      place_en_q    <= 1'b0;
      for (int i = 0; i < COLS; i++) height_q[i] <= '0;
      row_q         <= '0;
      col_q         <= '0;
      mover_red_q   <= 1'b0;
      red_player    <= '0;
      yellow_player <= '0;
      turn_red      <= FIRST_RED;
      busy          <= 1'b0;
      valid_move    <= 1'b0;
      invalid_move  <= 1'b0;
      game_over     <= 1'b0;
      winner        <= WIN_NONE;
      move_count    <= '0;
    end else begin
      state_q       <= state_d;
      place_en_q    <= place_en_d;
      for (int i = 0; i < COLS; i++) height_q[i] <= height_d[i];
      row_q         <= row_d;
      col_q         <= col_d;
      mover_red_q   <= mover_red_d;
      red_player    <= red_d;
      yellow_player <= yellow_d;
      turn_red      <= turn_red_d;
      busy          <= busy_d;
      valid_move    <= valid_d;
      invalid_move  <= invalid_d;
      game_over     <= game_over_d;
      winner        <= winner_d;
      move_count    <= move_count_d;
    end
  end

  // Next state, board update on accept, result capture at end of scan
  always_comb begin
    state_d      = state_q;
    place_en_d   = place_en;
    for (int i = 0; i < COLS; i++) height_d[i] = height_q[i];
    row_d        = row_q;
    col_d        = col_q;
    mover_red_d  = mover_red_q;
    red_d        = red_player;
    yellow_d     = yellow_player;
    turn_red_d   = turn_red;
    valid_d      = 1'b0;
    invalid_d    = 1'b0;
    game_over_d  = game_over;
    winner_d     = winner;
    move_count_d = move_count;

    one_hot = (col_switch != '0) && ((col_switch & (col_switch - COLS'(1))) == '0);
    sel_col = '0;
    for (int i = 0; i < COLS; i++) begin
      if (col_switch[i]) sel_col = CW'(i);
    end
    drop_bit = CELLS'(1) << cell_idx(32'(height_q[sel_col]), 32'(sel_col), COLS);

    unique case (state_q)
      S_IDLE: begin
        if (new_game) begin
          // Clear wins over a coincident place request
          place_en_d   = 1'b0;
          for (int i = 0; i < COLS; i++) height_d[i] = '0;
          red_d        = '0;
          yellow_d     = '0;
          turn_red_d   = FIRST_RED;
          game_over_d  = 1'b0;
          winner_d     = WIN_NONE;
          move_count_d = '0;
        end else if (place_req) begin
          if (!one_hot || (height_q[sel_col] == HW'(ROWS)) || game_over) begin
            invalid_d = 1'b1;
          end else begin
            row_d             = height_q[sel_col];
            col_d             = sel_col;
            mover_red_d       = turn_red;
            if (turn_red) red_d    = red_player | drop_bit;
            else          yellow_d = yellow_player | drop_bit;
            height_d[sel_col] = height_q[sel_col] + HW'(1);
            move_count_d      = move_count + MW'(1);
            valid_d           = 1'b1;
            state_d           = S_DROP;
          end
        end
      end
      S_DROP: state_d = S_CHECK;
      S_CHECK: begin
        if (scan_done) begin
          state_d = S_DONE;
          if (scan_win) begin
            game_over_d = 1'b1;
            winner_d    = mover_red_q ? WIN_RED : WIN_YELLOW;
          end else if (move_count == MW'(CELLS)) begin
            game_over_d = 1'b1;
            winner_d    = WIN_DRAW;
          end else begin
            turn_red_d  = ~turn_red;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_board_game_ctrl.sv
// Scoreboard bench for board_game_ctrl: a 6x7/4 instance and a 3x3/3 instance
// share stimulus; sel picks which one is driven and observed.
module tb_board_game_ctrl;

  typedef struct {
    bit          inv;
    logic [63:0] red;
    logic [63:0] yel;
    int          mc;
    bit          over;
    int          win;
    bit          turn;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [6:0] cs;
  logic pen, ng, sel;

  logic [41:0] b_red, b_yel;
  logic b_turn, b_busy, b_valid, b_invalid, b_over;
  logic [1:0] b_win;
  logic [5:0] b_mc;
  logic [8:0] s_red, s_yel;
  logic s_turn, s_busy, s_valid, s_invalid, s_over;
  logic [1:0] s_win;
  logic [3:0] s_mc;

  logic [63:0] o_red, o_yel;
  logic o_turn, o_busy, o_valid, o_invalid, o_over;
  logic [1:0] o_win;
  int o_mc;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int mb [8][8];
  int mh [8];
  int m_rows, m_cols, m_win, m_cnt, m_winner;
  bit m_turn, m_over;

  exp_t exp_q[$];
  exp_t pend;
  bit pend_v = 1'b0;
  int lat = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  board_game_ctrl #(.ROWS(6), .COLS(7), .WIN_LEN(4), .FIRST_RED(1'b1)) u_big (
    .clk(clk), .reset(rst_n), .col_switch(cs), .place_en(pen & ~sel), .new_game(ng),
    .red_player(b_red), .yellow_player(b_yel), .turn_red(b_turn), .busy(b_busy),
    .valid_move(b_valid), .invalid_move(b_invalid), .game_over(b_over),
    .winner(b_win), .move_count(b_mc)
  );

  board_game_ctrl #(.ROWS(3), .COLS(3), .WIN_LEN(3), .FIRST_RED(1'b1)) u_small (
    .clk(clk), .reset(rst_n), .col_switch(cs[2:0]), .place_en(pen & sel), .new_game(ng),
    .red_player(s_red), .yellow_player(s_yel), .turn_red(s_turn), .busy(s_busy),
    .valid_move(s_valid), .invalid_move(s_invalid), .game_over(s_over),
    .winner(s_win), .move_count(s_mc)
  );

  always_comb begin
    o_red     = sel ? 64'(s_red) : 64'(b_red);
    o_yel     = sel ? 64'(s_yel) : 64'(b_yel);
    o_turn    = sel ? s_turn : b_turn;
    o_busy    = sel ? s_busy : b_busy;
    o_valid   = sel ? s_valid : b_valid;
    o_invalid = sel ? s_invalid : b_invalid;
    o_over    = sel ? s_over : b_over;
    o_win     = sel ? s_win : b_win;
    o_mc      = sel ? int'(s_mc) : int'(b_mc);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic void model_set(int rows, int cols, int win);
    m_rows = rows; m_cols = cols; m_win = win;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 8; r++) begin
      mh[r] = 0;
      for (int c = 0; c < 8; c++) mb[r][c] = 0;
    end
    m_cnt = 0; m_turn = 1'b1; m_over = 1'b0; m_winner = 0;
  endfunction

  function automatic int run_len(int r, int c, int dr, int dc, int who);
    int n = 0;
    int rr = r + dr;
    int cc = c + dc;
    while (rr >= 0 && rr < m_rows && cc >= 0 && cc < m_cols && mb[rr][cc] == who) begin
      n++; rr += dr; cc += dc;
    end
    return n;
  endfunction

  function automatic exp_t model_place(logic [6:0] mask);
    exp_t e;
    int ones = 0, col = 0, who, r;
    bit won = 1'b0;
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int i = 0; i < m_cols; i++) if (mask[i]) begin ones++; col = i; end
    e.inv = (ones != 1) || m_over || (mh[col] == m_rows);
    if (!e.inv) begin
      who = m_turn ? 1 : 2;
      r = mh[col];
      mb[r][col] = who; mh[col]++; m_cnt++;
      for (int d = 0; d < 4; d++)
        if (1 + run_len(r, col, dr[d], dc[d], who) + run_len(r, col, -dr[d], -dc[d], who) >= m_win) won = 1'b1;
      if (won) begin m_over = 1'b1; m_winner = who; end
      else if (m_cnt == m_rows * m_cols) begin m_over = 1'b1; m_winner = 3; end
      else m_turn = ~m_turn;
    end
    e.red = '0; e.yel = '0;
    for (int rr = 0; rr < m_rows; rr++)
      for (int cc = 0; cc < m_cols; cc++) begin
        if (mb[rr][cc] == 1) e.red[rr * m_cols + cc] = 1'b1;
        if (mb[rr][cc] == 2) e.yel[rr * m_cols + cc] = 1'b1;
      end
    e.mc = m_cnt; e.over = m_over; e.win = m_winner; e.turn = m_turn;
    return e;
  endfunction

  // Monitor: pop an expectation on each move pulse; settle outcome when busy falls
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_valid || o_invalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_move_pulse", {62'd0, o_valid, o_invalid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_is_invalid", 64'(o_invalid), 64'(e.inv));
          chk("pulse_is_valid", 64'(o_valid), 64'(!e.inv));
          chk("red_board", o_red, e.red);
          chk("yellow_board", o_yel, e.yel);
          chk("move_count", 64'(o_mc), 64'(e.mc));
          if (o_invalid) begin
            chk("rej_game_over", 64'(o_over), 64'(e.over));
            chk("rej_winner", 64'(o_win), 64'(e.win));
            chk("rej_turn_red", 64'(o_turn), 64'(e.turn));
          end else begin
            pend = e; pend_v = 1'b1; lat = 0;
          end
        end
      end else if (pend_v) begin
        lat++;
        if (!o_busy) begin
          chk("game_over", 64'(o_over), 64'(pend.over));
          chk("winner", 64'(o_win), 64'(pend.win));
          chk("turn_red", 64'(o_turn), 64'(pend.turn));
          chk("busy_fall_latency_ok", 64'(lat <= 8 * (m_win - 1) + 2), 64'd1);
          pend_v = 1'b0;
        end
      end
    end
  end

  task automatic do_move(logic [6:0] mask, int hold);
    int k = 0;
    exp_q.push_back(model_place(mask));
    cs = mask; pen = 1'b1;
    repeat (hold) @(negedge clk);
    pen = 1'b0;
    while (k < 4 || (o_busy && k < 80)) begin @(negedge clk); k++; end
    chk("busy_settled", 64'(o_busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_cleared(string tag);
    chk({tag, "_red"}, o_red, 64'd0);
    chk({tag, "_yellow"}, o_yel, 64'd0);
    chk({tag, "_move_count"}, 64'(o_mc), 64'd0);
    chk({tag, "_turn_red"}, 64'(o_turn), 64'd1);
    chk({tag, "_game_over"}, 64'(o_over), 64'd0);
    chk({tag, "_winner"}, 64'(o_win), 64'd0);
  endtask

  task automatic do_new_game();
    ng = 1'b1;
    @(negedge clk);
    ng = 1'b0;
    model_clear();
    check_cleared("new_game");
  endtask

  task automatic play_cols(int cols[$]);
    foreach (cols[i]) do_move(7'(1) << cols[i], 1);
  endtask

  task automatic random_game();
    logic [6:0] mask;
    logic [6:0] colmask;
    colmask = 7'((1 << m_cols) - 1);
    do_new_game();
    for (int i = 0; i < 60 && !m_over; i++) begin
      if ($urandom_range(0, 9) == 0) mask = 7'($urandom()) & colmask;
      else mask = 7'(1) << $urandom_range(0, m_cols - 1);
      do_move(mask, int'($urandom_range(1, 3)));
    end
    if (m_over) do_move(7'(1) << $urandom_range(0, m_cols - 1), 1);
  endtask

  initial begin
    rst_n = 1'b0; cs = '0; pen = 1'b0; ng = 1'b0; sel = 1'b0;
    model_set(6, 7, 4); model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_cleared("reset");
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_invalid", 64'(o_invalid), 64'd0);

    // Held place_en on column 3: one move only
    do_move(7'b0001000, 10);
    chk("held_red_bit3", o_red, 64'h8);

    // Alternation and gravity on column 2
    do_new_game();
    play_cols('{2, 2, 2, 2});
    chk("stack_red", o_red, (64'd1 << 2) | (64'd1 << 16));
    chk("stack_yellow", o_yel, (64'd1 << 9) | (64'd1 << 23));

    // Full column then overflow
    do_new_game();
    play_cols('{0, 0, 0, 0, 0, 0, 0});

    // Vertical red win, then a rejected request
    do_new_game();
    play_cols('{0, 1, 0, 1, 0, 1, 0, 4});
    chk("vertical_winner", 64'(o_win), 64'd1);

    // Yellow anti-diagonal (0,4),(1,3),(2,2),(3,1)
    do_new_game();
    play_cols('{3, 4, 2, 3, 2, 6, 1, 2, 1, 6, 1, 1});
    chk("antidiag_winner", 64'(o_win), 64'd2);

    // Non one-hot column, then new_game colliding with a place request
    do_new_game();
    do_move(7'b0000011, 1);
    do_move(7'b0100000, 1);
    cs = 7'b0001000; pen = 1'b1; ng = 1'b1;
    @(negedge clk);
    pen = 1'b0; ng = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_cleared("collide");

    repeat (4) random_game();

    // Small board: draw without any line of three
    sel = 1'b1;
    model_set(3, 3, 3);
    do_new_game();
    play_cols('{1, 0, 2, 1, 0, 2, 0, 1, 2});
    chk("draw_winner", 64'(o_win), 64'd3);
    chk("draw_move_count", 64'(o_mc), 64'd9);
    do_new_game();
    do_move(7'b0000011, 1);
    repeat (6) random_game();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("no_pending_outcome", 64'(pend_v), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
